// File: rtl/pe_alu_core.sv
// PE tile compute stage: elastic valid/ready ALU with a pipelined 2-cycle MUL/MAC.
// The result register feeds back to the switch matrix.
module pe_alu_core #(
    parameter int DATA_WIDTH   = 32,
    parameter int NoConfigBits = 5
) (
    input  logic                    UserCLK,
    input  logic                    RESETn,
    input  logic [DATA_WIDTH-1:0]   data_in1,
    input  logic [DATA_WIDTH-1:0]   data_in2,
    input  logic [DATA_WIDTH-1:0]   data_in3,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    acc_clr,
    input  logic [NoConfigBits-1:0] ConfigBits
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_MUL  = 4'd7;
    localparam logic [3:0] OP_MAC  = 4'd8;
    localparam logic [3:0] OP_SEL  = 4'd9;
    localparam logic [3:0] OP_LT   = 4'd10;
    localparam logic [3:0] OP_MIN  = 4'd11;
    localparam logic [3:0] OP_MAX  = 4'd12;
    localparam logic [3:0] OP_ADD3 = 4'd13;
    localparam logic [3:0] OP_PASS = 4'd14;

    typedef enum logic [1:0] {
        IDLE,
        MUL1,
        MUL2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] pp0_q, pp0_d;
    logic [DATA_WIDTH-1:0] pp1_q, pp1_d;
    logic [DATA_WIDTH-1:0] pp2_q, pp2_d;
    logic                  is_mac_q, is_mac_d;
    logic                  live_q, live_d;

    logic [3:0]            cfg_op;
    logic                  cfg_signed;
    logic                  out_free;
    logic                  accept;
    logic                  alu_lt;
    logic [4:0]            shamt;
    logic signed [DATA_WIDTH-1:0] sra_res;
    logic [DATA_WIDTH-1:0] alu_res;
    logic [DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0] acc_base;
    logic [DATA_WIDTH-1:0] acc_sum;

    assign cfg_op     = ConfigBits[3:0];
    assign cfg_signed = ConfigBits[4];

    // live_q keeps in_ready low during reset and for the release cycle
    assign out_free = !out_valid_q || out_ready;
    assign in_ready = live_q && (state_q == IDLE) && out_free;
    assign accept   = in_valid && in_ready;

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;

    always_comb begin
        alu_lt  = cfg_signed ? ($signed(data_in1) < $signed(data_in2))
                             : (data_in1 < data_in2);
        shamt   = data_in2[4:0];
        sra_res = $signed(data_in1) >>> shamt;
        alu_res = '0;
        case (cfg_op)
            OP_ADD:  alu_res = data_in1 + data_in2;
            OP_SUB:  alu_res = data_in1 - data_in2;
            OP_AND:  alu_res = data_in1 & data_in2;
            OP_OR:   alu_res = data_in1 | data_in2;
            OP_XOR:  alu_res = data_in1 ^ data_in2;
            OP_SHL:  alu_res = data_in1 << shamt;
            OP_SHR:  alu_res = cfg_signed ? sra_res : (data_in1 >> shamt);
            OP_SEL:  alu_res = data_in3[0] ? data_in1 : data_in2;
            OP_LT:   alu_res = {{(DATA_WIDTH-1){1'b0}}, alu_lt};
            OP_MIN:  alu_res = alu_lt ? data_in1 : data_in2;
            OP_MAX:  alu_res = alu_lt ? data_in2 : data_in1;
            OP_ADD3: alu_res = data_in1 + data_in2 + data_in3;
            OP_PASS: alu_res = data_in1;
            default: alu_res = '0;
        endcase
    end

    // The A[31:16]*B[31:16] term only affects bits above 31 and is dropped
    assign prod     = pp0_q + ((pp1_q + pp2_q) << 16);
    assign acc_base = acc_clr ? '0 : acc_q;
    assign acc_sum  = acc_base + prod;

    always_comb begin
        state_d     = state_q;
        data_out_d  = data_out_q;
        out_valid_d = out_valid_q && !out_ready;
        acc_d       = acc_base;
        pp0_d       = pp0_q;
        pp1_d       = pp1_q;
        pp2_d       = pp2_q;
        is_mac_d    = is_mac_q;
        live_d      = 1'b1;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cfg_op == OP_MUL || cfg_op == OP_MAC) begin
                        state_d  = MUL1;
                        is_mac_d = (cfg_op == OP_MAC);
                        pp0_d    = {16'b0, data_in1[15:0]}  * {16'b0, data_in2[15:0]};
                        pp1_d    = {16'b0, data_in1[31:16]} * {16'b0, data_in2[15:0]};
                        pp2_d    = {16'b0, data_in1[15:0]}  * {16'b0, data_in2[31:16]};
                    end else begin
                        data_out_d  = alu_res;
                        out_valid_d = 1'b1;
                    end
                end
            end
            MUL1: begin
                state_d = MUL2;
            end
            MUL2: begin
                if (out_free) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    if (is_mac_q) begin
                        acc_d      = acc_sum;
                        data_out_d = acc_sum;
                    end else begin
                        data_out_d = prod;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge UserCLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q     <= IDLE;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            pp0_q       <= '0;
            pp1_q       <= '0;
            pp2_q       <= '0;
            is_mac_q    <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            acc_q       <= acc_d;
            pp0_q       <= pp0_d;
            pp1_q       <= pp1_d;
            pp2_q       <= pp2_d;
            is_mac_q    <= is_mac_d;
            live_q      <= live_d;
        end
    end

endmodule
